// File: rtl/mux41_pkg.sv
// Shared types and constants for the 4:1 round-robin stream merger.
// Channel indices are carried as sel_t throughout the design.
package mux41_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t RST_SEL = 2'b00;

    function automatic logic [CH_NUM-1:0] ch_onehot(input sel_t idx);
        logic [CH_NUM-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Latency: purely combinational.
// Backpressure: none; gnt_any=0 when no request is set.
module rr_pick4
    import mux41_pkg::*;
(
    input  logic [CH_NUM-1:0] req,
    input  sel_t              ptr,
    output sel_t              gnt_idx,
    output logic              gnt_any
);

    sel_t cand;

    // Walk from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        gnt_idx = ptr;
        gnt_any = 1'b0;
        cand    = ptr;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            cand = ptr + sel_t'(k);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux41_rr.sv
// 4:1 valid/ready stream merger, round-robin per beat (per burst with MUX41_HOLD_EN).
// Latency: 1 cycle accept -> out_valid; 1 beat/cycle when out_ready stays high.
// Backpressure: in_ready is granted only when the output register is empty or draining.
module mux41_rr
    import mux41_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [CH_NUM*DATA_W-1:0] in_data,
    input  logic [CH_NUM-1:0]        in_valid,
    input  logic [CH_NUM-1:0]        in_last,
    output logic [CH_NUM-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [DATA_W-1:0] ch_data [CH_NUM];
    logic [CH_NUM-1:0] req;
    sel_t              gnt_idx;
    logic              gnt_any;
    logic              load;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    sel_t              out_sel_q,   out_sel_d;
    logic              out_last_q,  out_last_d;
    sel_t              ptr_q,       ptr_d;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end

`ifdef MUX41_HOLD_EN
    logic lock_q,    lock_d;
    sel_t lock_ch_q, lock_ch_d;

    // A burst in progress masks every channel except its owner.
    always_comb begin
        req = in_valid;
        if (lock_q) begin
            req = in_valid & ch_onehot(lock_ch_q);
        end
    end
`else
    assign req = in_valid;
`endif

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign load     = en && (!out_valid_q || out_ready) && gnt_any;
    assign in_ready = (load && !rst) ? ch_onehot(gnt_idx) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;
`ifdef MUX41_HOLD_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gnt_idx];
            out_sel_d   = gnt_idx;
            out_last_d  = in_last[gnt_idx];
            ptr_d       = gnt_idx + sel_t'(1);
`ifdef MUX41_HOLD_EN
            lock_d      = !in_last[gnt_idx];
            lock_ch_d   = gnt_idx;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= RST_SEL;
            out_last_q  <= 1'b0;
            ptr_q       <= RST_SEL;
`ifdef MUX41_HOLD_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= RST_SEL;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            ptr_q       <= ptr_d;
`ifdef MUX41_HOLD_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux41_rr.sv
// Bench for mux41_rr: directed scenarios plus randomized traffic against a behavioural model.
module tb_mux41_rr;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    bit       m_vld;
    bit [7:0] m_dat;
    int       m_sel;
    bit       m_last;
    int       m_ptr;
    bit       m_lock;
    int       m_lock_ch;

    mux41_rr #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_dat = 0; m_sel = 0; m_last = 0;
        m_ptr = 0; m_lock = 0; m_lock_ch = 0;
    endtask

    function automatic bit eligible(input int c);
        bit ok;
        ok = in_valid[c];
`ifdef MUX41_HOLD_EN
        if (m_lock && c != m_lock_ch) ok = 0;
`endif
        return ok;
    endfunction

    // One clock: check at the falling edge, then advance the model on the rising edge.
    task automatic step();
        int  g;
        bit  ld;
        logic [3:0] exp_rdy;
        @(negedge clk);
        if (rst) model_reset();
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && eligible((m_ptr + k) % 4)) g = (m_ptr + k) % 4;
        end
        ld = !rst && en && (!m_vld || out_ready) && (g >= 0);
        exp_rdy = 4'b0000;
        if (ld) exp_rdy[g] = 1'b1;
        check("in_ready",  in_ready,  exp_rdy);
        check("out_valid", out_valid, m_vld);
        check("out_data",  out_data,  m_dat);
        check("out_sel",   out_sel,   m_sel);
        check("out_last",  out_last,  m_last);
        @(posedge clk);
        if (!rst) begin
            if (ld) begin
                m_vld  = 1;
                m_dat  = in_data[g*8 +: 8];
                m_sel  = g;
                m_last = in_last[g];
                m_ptr  = (g + 1) % 4;
                if (in_last[g]) m_lock = 0;
                else begin
                    m_lock    = 1;
                    m_lock_ch = g;
                end
            end else if (m_vld && out_ready) begin
                m_vld = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        int exp6 [4];
        rst = 1; en = 1; in_data = 32'h0; in_valid = 4'b0; in_last = 4'b0; out_ready = 1;
        model_reset();
        step();
        rst = 0;

        // Round-robin with all channels busy
        in_data = 32'h44332211; in_valid = 4'b1111; in_last = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_sel", out_sel, i % 4);
        end

        // Asynchronous reset while a beat is held
        check("pre_rst_vld", out_valid, 1);
        rst = 1;
        #1;
        check("rst_vld",   out_valid, 0);
        check("rst_sel",   out_sel,   0);
        check("rst_rdy",   in_ready,  0);
        check("rst_data",  out_data,  0);
        step();
        rst = 0;

        // Backpressure on a ch2 beat
        in_valid = 4'b0100; in_data = 32'h00A50000; out_ready = 0;
        step();
        in_valid = 4'b1111; in_data = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_data", out_data, 8'hA5);
            check("bp_sel",  out_sel,  2);
            check("bp_rdy",  in_ready, 0);
        end
        out_ready = 1; in_valid = 4'b0000;
        step();
        step();

        // Enable gating keeps ptr frozen
        do_reset();
        en = 0; in_valid = 4'b0100; in_data = 32'h005A0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_rdy", in_ready, 0);
        end
        en = 1;
        step();
        check("en_sel",  out_sel,  2);
        check("en_data", out_data, 8'h5A);
        in_valid = 4'b1111;
        step();
        check("en_next", out_sel, 3);

        // Skipping idle channels from ptr=1
        do_reset();
        in_valid = 4'b0001;
        step();
        in_valid = 4'b1001;
        step();
        check("skip_a", out_sel, 3);
        step();
        check("skip_b", out_sel, 0);

        // Burst from ch1 with ch0/ch2 competing
        do_reset();
        in_valid = 4'b0001; in_last = 4'b0001;
        step();
`ifdef MUX41_HOLD_EN
        exp6 = '{1, 1, 1, 2};
`else
        exp6 = '{1, 2, 0, 1};
`endif
        in_valid = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            in_last = {1'b1, 1'b1, (i == 2), 1'b1};
            step();
            check("burst_sel", out_sel, exp6[i]);
        end

        // Randomized traffic
        in_valid = 4'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            in_data   = $urandom;
            step();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
